// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types for the initiator: response codes, master FSM states
// and the fixed protection attribute.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_READ,
    ST_RDATA
  } mst_state_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return axi_resp_t'(resp) != OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// Unified AXI4-Lite bundle shared by the initiator and the peripheral-side slave.
interface axi4_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_read_master.sv
// Read half of the initiator: AR address phase, then R data capture.
// state    | meaning
// ST_IDLE  | no read in flight, rdata holds the last completed load
// ST_READ  | ARVALID up until ARREADY
// ST_RDATA | RREADY up, waiting for the read data beat
module axi4_lite_read_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  idle,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  mst_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  assign arvalid = (state_q == ST_READ);
  assign rready  = (state_q == ST_RDATA);
  assign idle    = (state_q == ST_IDLE);
  assign araddr  = araddr_q;
  assign rdata   = rdata_q;
  assign done    = done_q;
  assign err     = err_q;

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_READ;
          araddr_d = req_addr;
        end
      end
      ST_READ: begin
        if (arready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (rvalid) begin
          rdata_d = axi_rdata;
          err_d   = resp_is_err(rresp);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      araddr_q <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: rtl/axi4_lite_write_master.sv
// Write half of the initiator: drives AW/W together, then waits for B.
// state    | meaning
// ST_IDLE  | no write in flight, payload registers hold last request
// ST_WRITE | AWVALID/WVALID up until each channel's own handshake
// ST_WRESP | BREADY up, waiting for the write response
module axi4_lite_write_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en,
  output logic                    idle,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  mst_state_e              state_q, state_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  // VALID/READY are pure decodes of flops so an async reset drops them at once
  assign awvalid = (state_q == ST_WRITE) && !aw_done_q;
  assign wvalid  = (state_q == ST_WRITE) && !w_done_q;
  assign bready  = (state_q == ST_WRESP);
  assign idle    = (state_q == ST_IDLE);
  assign awaddr  = awaddr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign done    = done_q;
  assign err     = err_q;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_WRITE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awaddr_d  = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_byte_en;
        end
      end
      ST_WRITE: begin
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        if (bvalid) begin
          err_d   = resp_is_err(bresp);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns single-cycle core load/store strobes into one
// outstanding AXI4-Lite transaction and releases the core with a done pulse.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en,
  output logic                    req_ready,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  axi4_lite_if.master             master_if
);

  logic wr_idle, wr_done, wr_err;
  logic rd_idle, rd_done, rd_err;
  logic accept;
  logic last_wr_q, last_wr_d;

  assign req_ready = wr_idle && rd_idle;
  assign accept    = req_valid && req_ready;

  assign master_if.awprot = PROT_DEFAULT;
  assign master_if.arprot = PROT_DEFAULT;

  axi4_lite_write_master #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr (
    .clk         (clk),
    .rst         (rst),
    .start       (accept && req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_byte_en (req_byte_en),
    .idle        (wr_idle),
    .done        (wr_done),
    .err         (wr_err),
    .awaddr      (master_if.awaddr),
    .awvalid     (master_if.awvalid),
    .awready     (master_if.awready),
    .wdata       (master_if.wdata),
    .wstrb       (master_if.wstrb),
    .wvalid      (master_if.wvalid),
    .wready      (master_if.wready),
    .bresp       (master_if.bresp),
    .bvalid      (master_if.bvalid),
    .bready      (master_if.bready)
  );

  axi4_lite_read_master #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && !req_write),
    .req_addr  (req_addr),
    .idle      (rd_idle),
    .done      (rd_done),
    .err       (rd_err),
    .rdata     (rdata),
    .araddr    (master_if.araddr),
    .arvalid   (master_if.arvalid),
    .arready   (master_if.arready),
    .axi_rdata (master_if.rdata),
    .rresp     (master_if.rresp),
    .rvalid    (master_if.rvalid),
    .rready    (master_if.rready)
  );

  // err reports whichever side completed last; both sides hold their own copy
  always_comb begin
    last_wr_d = last_wr_q;
    if (accept) last_wr_d = req_write;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_wr_q <= 1'b0;
    else      last_wr_q <= last_wr_d;
  end

  assign done = wr_done || rd_done;
  assign err  = last_wr_q ? wr_err : rd_err;

endmodule
